// File: rtl/output_port_arbiter.sv
// Credit-based output-port arbiter: round-robin allocation among local/x/y
// requesters, packet-granular lock until tail, downstream credit counter.
module output_port_arbiter #(
    parameter int CREDIT_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [2:0] req,
    input  logic [2:0] tail,
    input  logic       credit_in,
    output logic [2:0] gnt,
    output logic       send_valid,
    output logic [2:0] credit_cnt,
    output logic       credit_err
);

    typedef enum logic {IDLE, LOCKED} state_t;

    localparam logic [2:0] CMAX = 3'(CREDIT_MAX);

    state_t     r_state;
    logic [1:0] r_ptr;
    logic [2:0] r_gnt;
    logic [2:0] r_credit;
    logic       r_err;

    logic [2:0] w_pick;
    logic [1:0] w_next_ptr;
    logic       w_own_req;
    logic       w_own_tail;
    logic       w_send;

    // Rotate so ptr lands on bit 0, take first set bit, rotate back.
    function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
        logic [2:0] rot;
        logic [2:0] g;
        case (p)
            2'd1:    rot = {r[0], r[2], r[1]};
            2'd2:    rot = {r[1], r[0], r[2]};
            default: rot = r;
        endcase
        g = rot[0] ? 3'b001 : rot[1] ? 3'b010 : rot[2] ? 3'b100 : 3'b000;
        case (p)
            2'd1:    rr_pick = {g[1], g[0], g[2]};
            2'd2:    rr_pick = {g[0], g[2], g[1]};
            default: rr_pick = g;
        endcase
    endfunction

    // gnt is one-hot while locked, so masking selects the owner's bits.
    assign w_pick     = rr_pick(req, r_ptr);
    assign w_own_req  = |(req & r_gnt);
    assign w_own_tail = |(tail & r_gnt);
    assign w_next_ptr = r_gnt[0] ? 2'd1 : r_gnt[1] ? 2'd2 : 2'd0;
    assign w_send     = en && (r_state == LOCKED) && w_own_req && (r_credit != 3'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_ptr    <= 2'd0;
            r_gnt    <= 3'b000;
            r_credit <= CMAX;
            r_err    <= 1'b0;
        end else begin
            if (en) begin
                case (r_state)
                    IDLE: begin
                        if (|req) begin
                            r_gnt   <= w_pick;
                            r_state <= LOCKED;
                        end
                    end
                    LOCKED: begin
                        if (w_send && w_own_tail) begin
                            r_state <= IDLE;
                            r_gnt   <= 3'b000;
                            r_ptr   <= w_next_ptr;
                        end
                        if (w_own_tail && !w_own_req)
                            r_err <= 1'b1;
                    end
                    default: r_state <= IDLE;
                endcase
            end
            // Credit returns are counted even while disabled.
            case ({credit_in, w_send})
                2'b10: begin
                    if (r_credit == CMAX)
                        r_err <= 1'b1;
                    else
                        r_credit <= r_credit + 3'd1;
                end
                2'b01:   r_credit <= r_credit - 3'd1;
                default: r_credit <= r_credit;
            endcase
        end
    end

    assign gnt        = r_gnt;
    assign send_valid = w_send;
    assign credit_cnt = r_credit;
    assign credit_err = r_err;

endmodule

// File: tb/tb_output_port_arbiter.sv
// Directed table-driven bench for output_port_arbiter (CREDIT_MAX=4) plus
// hand-written sequences for multi-flit packets and mid-packet reset.
module tb_output_port_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [2:0] req;
    logic [2:0] tail;
    logic       credit_in;
    logic [2:0] gnt;
    logic       send_valid;
    logic [2:0] credit_cnt;
    logic       credit_err;

    int errors = 0;
    int checks = 0;

    output_port_arbiter #(.CREDIT_MAX(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .tail      (tail),
        .credit_in (credit_in),
        .gnt       (gnt),
        .send_valid(send_valid),
        .credit_cnt(credit_cnt),
        .credit_err(credit_err)
    );

    always #5 clk = ~clk;

    // Inputs applied for one cycle; expected outputs observed during that cycle.
    typedef struct {
        logic       rst;
        logic       en;
        logic [2:0] req;
        logic [2:0] tail;
        logic       cin;
        logic [2:0] gnt;
        logic       sv;
        logic [2:0] cnt;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic e, input logic [2:0] rq, input logic [2:0] tl,
                       input logic ci, input logic [2:0] g, input logic s, input logic [2:0] c,
                       input logic er);
        vec_t v;
        v.rst = r; v.en = e; v.req = rq; v.tail = tl; v.cin = ci;
        v.gnt = g; v.sv = s; v.cnt = c; v.err = er;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b1; req = 3'b000; tail = 3'b000; credit_in = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; req = 3'b000; tail = 3'b000; credit_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        //   rst en  req     tail    cin  gnt     sv cnt  err
        add(0, 1, 3'b111, 3'b111, 0, 3'b000, 0, 3'd4, 0); // 0 reset
        add(1, 1, 3'b111, 3'b111, 0, 3'b000, 0, 3'd4, 0); // 1 first pick
        add(1, 1, 3'b111, 3'b111, 0, 3'b001, 1, 3'd4, 0); // 2 rr sequence
        add(1, 1, 3'b111, 3'b111, 0, 3'b000, 0, 3'd3, 0);
        add(1, 1, 3'b111, 3'b111, 0, 3'b010, 1, 3'd3, 0);
        add(1, 1, 3'b111, 3'b111, 0, 3'b000, 0, 3'd2, 0);
        add(1, 1, 3'b111, 3'b111, 0, 3'b100, 1, 3'd2, 0);
        add(1, 1, 3'b111, 3'b111, 0, 3'b000, 0, 3'd1, 0);
        add(1, 1, 3'b111, 3'b111, 0, 3'b001, 1, 3'd1, 0); // 8
        add(1, 1, 3'b000, 3'b000, 1, 3'b000, 0, 3'd0, 0); // 9 credit refill
        add(1, 1, 3'b000, 3'b000, 1, 3'b000, 0, 3'd1, 0);
        add(1, 1, 3'b000, 3'b000, 1, 3'b000, 0, 3'd2, 0);
        add(1, 1, 3'b000, 3'b000, 1, 3'b000, 0, 3'd3, 0);
        add(1, 1, 3'b000, 3'b000, 1, 3'b000, 0, 3'd4, 0); // 13 overflow
        add(1, 1, 3'b000, 3'b000, 0, 3'b000, 0, 3'd4, 1); // 14 sticky err
        add(0, 1, 3'b000, 3'b000, 0, 3'b000, 0, 3'd4, 0); // 15 reset clears err
        add(1, 1, 3'b001, 3'b000, 0, 3'b000, 0, 3'd4, 0); // 16 long packet
        add(1, 1, 3'b001, 3'b000, 0, 3'b001, 1, 3'd4, 0);
        add(1, 1, 3'b001, 3'b000, 0, 3'b001, 1, 3'd3, 0);
        add(1, 1, 3'b001, 3'b000, 0, 3'b001, 1, 3'd2, 0);
        add(1, 1, 3'b001, 3'b000, 0, 3'b001, 1, 3'd1, 0);
        add(1, 1, 3'b001, 3'b000, 0, 3'b001, 0, 3'd0, 0); // 21 out of credit
        add(1, 1, 3'b001, 3'b000, 1, 3'b001, 0, 3'd0, 0); // 22 one credit back
        add(1, 1, 3'b001, 3'b000, 0, 3'b001, 1, 3'd1, 0);
        add(1, 1, 3'b001, 3'b000, 0, 3'b001, 0, 3'd0, 0);
        add(1, 1, 3'b001, 3'b000, 1, 3'b001, 0, 3'd0, 0); // 25
        add(1, 1, 3'b000, 3'b000, 1, 3'b001, 0, 3'd1, 0); // 26 owner stall
        add(1, 1, 3'b001, 3'b000, 1, 3'b001, 1, 3'd2, 0); // 27 send+credit
        add(1, 1, 3'b001, 3'b001, 0, 3'b001, 1, 3'd2, 0); // 28 tail
        add(1, 1, 3'b000, 3'b000, 0, 3'b000, 0, 3'd1, 0);
        add(1, 1, 3'b100, 3'b000, 0, 3'b000, 0, 3'd1, 0); // 30 ptr=1 -> y
        add(1, 1, 3'b100, 3'b000, 1, 3'b100, 1, 3'd1, 0);
        add(1, 0, 3'b100, 3'b100, 0, 3'b100, 0, 3'd1, 0); // 32 disabled
        add(1, 0, 3'b100, 3'b100, 0, 3'b100, 0, 3'd1, 0);
        add(1, 0, 3'b111, 3'b100, 0, 3'b100, 0, 3'd1, 0);
        add(1, 1, 3'b100, 3'b100, 0, 3'b100, 1, 3'd1, 0); // 35 resume
        add(1, 1, 3'b110, 3'b000, 1, 3'b000, 0, 3'd0, 0); // 36 ptr=0 -> x
        add(1, 1, 3'b100, 3'b010, 0, 3'b010, 0, 3'd1, 0); // 37 tail w/o req
        add(1, 1, 3'b000, 3'b000, 0, 3'b010, 0, 3'd1, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n = vecs[i].rst; en = vecs[i].en; req = vecs[i].req;
            tail = vecs[i].tail; credit_in = vecs[i].cin;
            #1;
            chk($sformatf("v%0d gnt", i), {5'd0, gnt}, {5'd0, vecs[i].gnt});
            chk($sformatf("v%0d send_valid", i), {7'd0, send_valid}, {7'd0, vecs[i].sv});
            chk($sformatf("v%0d credit_cnt", i), {5'd0, credit_cnt}, {5'd0, vecs[i].cnt});
            chk($sformatf("v%0d credit_err", i), {7'd0, credit_err}, {7'd0, vecs[i].err});
            @(posedge clk); #1;
        end

        // x owns a 3-flit packet while y waits
        do_reset();
        req = 3'b110; tail = 3'b000;
        @(posedge clk); #1;
        for (int c = 0; c < 3; c++) begin
            tail = (c == 2) ? 3'b010 : 3'b000;
            #1;
            chk($sformatf("pkt3 gnt c%0d", c), {5'd0, gnt}, 8'h02);
            chk($sformatf("pkt3 sv c%0d", c), {7'd0, send_valid}, 8'h01);
            @(posedge clk); #1;
        end
        req = 3'b100; tail = 3'b000;
        #1;
        chk("pkt3 bubble", {5'd0, gnt}, 8'h00);
        @(posedge clk); #1;
        chk("pkt3 next y", {5'd0, gnt}, 8'h04);
        chk("pkt3 credits", {5'd0, credit_cnt}, 8'h01);

        // reset in the middle of a packet
        do_reset();
        req = 3'b001; tail = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst pre cnt", {5'd0, credit_cnt}, 8'h02);
        rst_n = 1'b0;
        #1;
        chk("midrst gnt", {5'd0, gnt}, 8'h00);
        chk("midrst cnt", {5'd0, credit_cnt}, 8'h04);
        chk("midrst sv", {7'd0, send_valid}, 8'h00);
        @(posedge clk); #1;
        rst_n = 1'b1; req = 3'b110;
        @(posedge clk); #1;
        chk("midrst regrant", {5'd0, gnt}, 8'h02);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/output_port_arbiter.md
OUTPUT_PORT_ARBITER -- requirements
Module: output_port_arbiter

Interface
REQ-001 The block SHALL have parameter CREDIT_MAX, default 4, meaning downstream input-buffer depth in flits (legal 1..7).
REQ-002 The block SHALL have port clk  input  1  rising-edge clock.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port en  input  1  global enable; when 0, all state holds and send_valid=0.
REQ-005 The block SHALL have port req  input  3  per-requester request for this output; bit0 local, bit1 x, bit2 y.
REQ-006 The block SHALL have port tail  input  3  per-requester flag: the current head-of-line flit is a tail flit.
REQ-007 The block SHALL have port credit_in  input  1  one-cycle pulse returning one downstream buffer slot.
REQ-008 The block SHALL have port gnt  output  3  registered one-hot grant (crossbar select); 3'b000 means stop.
REQ-009 The block SHALL have port send_valid  output  1  combinational: the granted flit crosses this cycle.
REQ-010 The block SHALL have port credit_cnt  output  3  registered count of available downstream slots.
REQ-011 The block SHALL have port credit_err  output  1  registered sticky flag: credit overflow or protocol error.

Function
REQ-012 The FSM SHALL have two states: IDLE (gnt=000) and LOCKED (gnt one-hot, owner held).
REQ-013 In IDLE with en=1 and req!=0, the block SHALL pick the first set req bit in round-robin order starting at pointer ptr, load gnt on the next edge, and go to LOCKED; 1-cycle req-to-grant latency.
REQ-014 Allocation SHALL NOT depend on credit_cnt; a grant is issued even at credit_cnt=0.
REQ-015 send_valid SHALL equal en & LOCKED & req[owner] & (credit_cnt!=0).
REQ-016 In LOCKED, gnt SHALL hold until a cycle with send_valid=1 and tail[owner]=1; on that edge the FSM SHALL return to IDLE, gnt becomes 000, and ptr becomes (owner+1) mod 3.
REQ-017 If req[owner] drops while LOCKED, the block SHALL stall (send_valid=0) and keep the grant; no preemption.
REQ-018 Requests from non-owners while LOCKED SHALL be ignored and SHALL NOT change ptr.
REQ-019 A released port SHALL spend at least one cycle in IDLE before re-grant (1 idle bubble between packets).
REQ-020 credit_cnt SHALL decrement by 1 on send_valid, increment by 1 on credit_in, and stay unchanged when both occur in the same cycle.
REQ-021 credit_in at credit_cnt=CREDIT_MAX without a simultaneous send SHALL leave credit_cnt unchanged and set credit_err.
REQ-022 credit_err SHALL also set if tail[owner]=1 is observed with req[owner]=0 while LOCKED; credit_err clears only on reset.
REQ-023 credit_in SHALL be counted regardless of en.
REQ-024 Single-flit packets (head=tail) SHALL complete in one send cycle.

Reset
REQ-025 On rst_n=0, asynchronously: state=IDLE, gnt=000, ptr=0 (local first), credit_cnt=CREDIT_MAX, credit_err=0; send_valid therefore 0.
REQ-026 Reset asserted mid-packet SHALL abandon the lock with no partial state retained; after release, the first grant follows REQ-013 with ptr=0.

Verification
REQ-027 Reset; req=111 held, tail=111 -> gnt sequence 001,000,010,000,100,000,001 on successive cycles; credit_cnt 4,3,3,2,2,1,1 (the 000 entries are the REQ-019 idle bubbles).
REQ-028 Owner x sends a 3-flit packet (tail on the 3rd) while y requests -> gnt=010 for exactly 3 send cycles, then 000, then 100.
REQ-029 CREDIT_MAX=4; 4 sends with no credit_in -> credit_cnt=0 and send_valid=0 with gnt held; one credit_in pulse -> one send the next cycle, credit_cnt returns to 0.
REQ-030 Simultaneous send_valid and credit_in at credit_cnt=2 -> credit_cnt stays 2; a credit_in at 4 with no send -> credit_cnt=4 and credit_err=1 from the next cycle.
REQ-031 Assert rst_n=0 mid-packet, then release -> gnt=000 and credit_cnt=4 immediately; with req=110, the next grant is 010.
REQ-032 Drive en=0 for 3 cycles during LOCKED -> gnt, ptr and credit_cnt hold and send_valid=0; on resume, transfer continues.
